operand_bus_arbiter: RTL and testbench

OPERAND_BUS_ARBITER -- requirements
Module: operand_bus_arbiter

---
 rtl/operand_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_operand_bus_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_bus_arbiter.sv
// Operand bus arbiter: grants one of four sources (vector D, scalars A/B/C)
// to a single registered output bus using round-robin priority, holds the
// granted operand stable under backpressure, and pulses a one-hot ack on the
// cycle the consumer takes it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operand held; out_valid=0, any request is granted next edge
// HOLD  | out_data/out_sel hold the granted operand; waiting for out_ready
module operand_bus_arbiter #(
  parameter int S = 32,
  parameter int V = 192
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [V-1:0] D,
  input  logic [S-1:0] A,
  input  logic [S-1:0] B,
  input  logic [S-1:0] C,
  output logic [3:0]   ack,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [V-1:0] out_data,
  output logic [1:0]   out_sel,
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   ptr;
  logic [1:0]   ptr_nxt;
  logic [1:0]   sel_nxt;
  logic [V-1:0] data_nxt;

  logic         handshake;
  logic [3:0]   sel_onehot;
  logic [3:0]   eligible;
  logic [1:0]   start;
  logic [1:0]   idx;
  logic [1:0]   winner;
  logic         found;
  logic [V-1:0] win_data;

  // Handshake detection and the ack pulse for the currently held source.
  always_comb begin
    sel_onehot = 4'b0001 << out_sel;
    handshake  = (state == HOLD) && out_ready;
    ack        = (handshake && rst_n) ? sel_onehot : 4'b0000;
  end

  // Round-robin search; on a handshake the just-acked source is masked and
  // the search already starts from the advanced pointer so back-to-back
  // grants see the same priority order the registered pointer will hold.
  always_comb begin
    eligible = handshake ? (req & ~sel_onehot) : req;
    start    = handshake ? (out_sel + 2'd1) : ptr;
    found    = 1'b0;
    winner   = start;
    idx      = start;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Operand mux for the winner; scalars are zero-extended onto the wide bus.
  always_comb begin
    win_data = '0;
    case (winner)
      2'd0:    win_data = D;
      2'd1:    win_data = V'(A);
      2'd2:    win_data = V'(B);
      default: win_data = V'(C);
    endcase
  end

  // Next-state and next-register values for the two-state grant FSM.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = out_sel;
    data_nxt  = out_data;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = HOLD;
          sel_nxt   = winner;
          data_nxt  = win_data;
        end
      end
      HOLD: begin
        if (handshake) begin
          ptr_nxt = out_sel + 2'd1;
          if (found) begin
            sel_nxt  = winner;
            data_nxt = win_data;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and operand registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      out_sel  <= 2'd0;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      out_sel  <= sel_nxt;
      out_data <= data_nxt;
    end
  end

  // Valid and busy are the same view of the HOLD state.
  always_comb begin
    out_valid = (state == HOLD);
    busy      = out_valid;
  end

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Self-checking bench for operand_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle with a
// transaction-level reference model.
module tb_operand_bus_arbiter;
  localparam int S = 32;
  localparam int V = 192;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [V-1:0] D;
  logic [S-1:0] A, B, C;
  logic [3:0]   ack;
  logic         out_valid;
  logic         out_ready;
  logic [V-1:0] out_data;
  logic [1:0]   out_sel;
  logic         busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model of what the bus holds: valid flag, granted source, captured data, pointer.
  bit           m_valid = 1'b0;
  int           m_sel   = 0;
  logic [V-1:0] m_data  = '0;
  int           m_ptr   = 0;

  operand_bus_arbiter #(.S(S), .V(V)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .D(D), .A(A), .B(B), .C(C),
    .ack(ack), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [V-1:0] src_data(input int s);
    case (s)
      0:       return D;
      1:       return {{(V-S){1'b0}}, A};
      2:       return {{(V-S){1'b0}}, B};
      default: return {{(V-S){1'b0}}, C};
    endcase
  endfunction

  // First requesting source when walking the four sources from 'from' upward.
  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 0; k < 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  // Reference model: advance one transfer-level step per clock edge.
  always @(posedge clk) begin
    logic [3:0] cand;
    int         w;
    bit         free;
    if (!rst_n) begin
      m_valid = 1'b0; m_sel = 0; m_data = '0; m_ptr = 0;
    end else begin
      cand = req;
      free = !m_valid;
      if (m_valid && out_ready) begin
        m_ptr = (m_sel + 1) % 4;
        cand[m_sel] = 1'b0;
        free = 1'b1;
      end
      if (free) begin
        w = pick(cand, m_ptr);
        if (w < 0) m_valid = 1'b0;
        else begin
          m_valid = 1'b1; m_sel = w; m_data = src_data(w);
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] exp_ack;
    if (chk_en) begin
      exp_ack = (m_valid && out_ready && rst_n) ? (4'b0001 << m_sel) : 4'b0000;
      chk("out_valid", V'(out_valid), V'(m_valid));
      chk("busy", V'(busy), V'(m_valid));
      chk("ack", V'(ack), V'(exp_ack));
      if (m_valid) begin
        chk("out_sel", V'(out_sel), V'(m_sel));
        chk("out_data", out_data, m_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [V-1:0] ones;
    logic [V-1:0] rnd;
    ones = '1;
    rst_n = 1'b0; req = 4'b0; out_ready = 1'b0;
    D = '0; A = '0; B = '0; C = '0;
    tick(); chk_en = 1'b1; tick();
    @(negedge clk);
    chk("rst_valid", V'(out_valid), '0);
    chk("rst_busy", V'(busy), '0);
    chk("rst_sel", V'(out_sel), '0);
    chk("rst_data", out_data, '0);
    chk("rst_ack", V'(ack), '0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single scalar request.
    req = 4'b0010; A = 32'h12345678; tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("single_valid", V'(out_valid), V'(1));
    chk("single_sel", V'(out_sel), V'(2'b01));
    chk("single_data", out_data, V'(32'h12345678));
    chk("single_ack", V'(ack), V'(4'b0010));
    tick(); req = 4'b0;
    @(negedge clk);
    chk("single_idle", V'(out_valid), '0);
    chk("single_ack_off", V'(ack), '0);

    // Round-robin with all requesting and no backpressure, from ptr=0.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = 4'b1111; out_ready = 1'b1;
    D = {6{32'hA5A5_0001}}; A = 32'h11; B = 32'h22; C = 32'h33;
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_sel", V'(out_sel), V'(i % 4));
      chk("rr_ack", V'(ack), V'(4'b0001 << (i % 4)));
      tick();
    end
    req = 4'b0; tick(); out_ready = 1'b0;

    // Backpressure on a vector grant.
    req = 4'b0001; D = ones; tick();
    D = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data", out_data, ones);
      chk("bp_ack", V'(ack), '0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ack_rel", V'(ack), V'(4'b0001));
    chk("bp_data_rel", out_data, ones);
    tick(); req = 4'b0;

    // Wrap from ptr=3 and masking of the acked source.
    req = 4'b0100; B = 32'hB0B0; tick();
    @(negedge clk);
    chk("wrap_b_ack", V'(ack), V'(4'b0100));
    tick(); req = 4'b1001; C = 32'hC0C0;
    @(negedge clk);
    chk("wrap_idle", V'(out_valid), '0);
    tick();
    @(negedge clk);
    chk("wrap_c_sel", V'(out_sel), V'(2'd3));
    chk("wrap_c_ack", V'(ack), V'(4'b1000));
    tick(); req = 4'b0001;
    @(negedge clk);
    chk("wrap_d_sel", V'(out_sel), V'(2'd0));
    chk("wrap_d_ack", V'(ack), V'(4'b0001));
    tick();
    @(negedge clk);
    chk("mask_gap", V'(out_valid), '0);
    tick(); req = 4'b0;
    @(negedge clk);
    chk("mask_regrant", V'(out_valid), V'(1));
    tick(); out_ready = 1'b0;

    // Reset while holding a grant.
    req = 4'b0100; tick();
    rst_n = 1'b0; out_ready = 1'b1; req = 4'b1111;
    @(negedge clk);
    chk("rsthold_ack", V'(ack), '0);
    tick(); rst_n = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("rsthold_valid", V'(out_valid), '0);
    tick();
    @(negedge clk);
    chk("rsthold_first_d", V'(out_sel), V'(2'd0));
    req = 4'b0; out_ready = 1'b1; tick(); out_ready = 1'b0; tick();

    // Requester drops req after being granted.
    req = 4'b1000; C = 32'hCAFEBABE; tick();
    req = 4'b0; C = 32'h0;
    tick(); tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("drop_ack", V'(ack), V'(4'b1000));
    chk("drop_data", out_data, V'(32'hCAFEBABE));
    tick(); out_ready = 1'b0;

    // Randomized traffic, checked by the compare process against the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 63) != 0);
      req       = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 2) != 0);
      for (int w = 0; w < 6; w++) rnd[w*32 +: 32] = $urandom;
      D = rnd; A = $urandom; B = $urandom; C = $urandom;
      tick();
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
